// File: rtl/cic_pkg.sv
// Shared types and default parameters for the CIC decimation controller.
package cic_pkg;

    localparam int unsigned SHIFT_W        = 6;
    localparam int unsigned DEF_WIDTH      = 64;
    localparam int unsigned DEF_OUT_WIDTH  = 16;
    localparam int unsigned DEF_NUM_STAGES = 5;
    localparam int unsigned DEF_DEC_WIDTH  = 10;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StWarmup,
        StRun
    } cic_state_e;

endpackage

// File: rtl/cic_decim_counter.sv
// Decimation counter: counts gated input samples and emits a tick on the
// sample that completes each group of (ratio + 1) samples.
module cic_decim_counter #(
    parameter int unsigned DEC_WIDTH = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic                 sample_i,
    input  logic [DEC_WIDTH-1:0] ratio_i,
    output logic                 tick_o
);

    logic [DEC_WIDTH-1:0] cnt_q;
    logic                 step;

    assign step   = en_i && sample_i;
    assign tick_o = step && (cnt_q == ratio_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (step) begin
            cnt_q <= tick_o ? '0 : cnt_q + DEC_WIDTH'(1);
        end
    end

endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC decimation sequencer: clear/warm-up/run control, comb tick, scaled capture
// and valid/ready output. Define CIC_DECIM_ROUND_EN for round-half-up scaling.
module cic_decim_ctrl
    import cic_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
    parameter int unsigned DEC_WIDTH  = DEF_DEC_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_en_i,
    input  logic [DEC_WIDTH-1:0] cfg_decim_i,
    input  logic [SHIFT_W-1:0]   cfg_shift_i,
    input  logic                 sample_valid_i,
    output logic                 integ_en_o,
    output logic                 comb_en_o,
    output logic                 cic_clr_o,
    input  logic [WIDTH-1:0]     comb_data_i,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int unsigned        WARM_W    = $clog2(NUM_STAGES + 1);
    localparam logic [SHIFT_W-1:0] MAX_SHIFT = SHIFT_W'(WIDTH - OUT_WIDTH);

    cic_state_e           state_q;
    logic [DEC_WIDTH-1:0] decim_q;
    logic [SHIFT_W-1:0]   shift_q;
    logic [WARM_W-1:0]    warm_q;
    logic                 comb_en_q, cap_q, clr_q, ovr_q, valid_q;
    logic [OUT_WIDTH-1:0] data_q;

    logic                 active, abort, tick;
    logic [SHIFT_W-1:0]   eff_shift;
    logic [WIDTH-1:0]     pre_sel;
    logic [OUT_WIDTH-1:0] sel_data;

    assign active     = (state_q == StWarmup) || (state_q == StRun);
    assign abort      = !cfg_en_i && (state_q != StIdle);
    assign integ_en_o = active && sample_valid_i;
    assign busy_o     = (state_q != StIdle);

    assign comb_en_o    = comb_en_q;
    assign cic_clr_o    = clr_q;
    assign overrun_o    = ovr_q;
    assign data_valid_o = valid_q;
    assign data_o       = data_q;

    cic_decim_counter #(
        .DEC_WIDTH (DEC_WIDTH)
    ) u_counter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (state_q == StClear),
        .en_i     (active),
        .sample_i (sample_valid_i),
        .ratio_i  (decim_q),
        .tick_o   (tick)
    );

    assign eff_shift = (shift_q > MAX_SHIFT) ? MAX_SHIFT : shift_q;

`ifdef CIC_DECIM_ROUND_EN
    logic [WIDTH-1:0] round_add;
    assign round_add = (eff_shift == '0) ? '0 : (WIDTH'(1) << (eff_shift - SHIFT_W'(1)));
    assign pre_sel   = comb_data_i + round_add;
`else
    assign pre_sel = comb_data_i;
`endif

    assign sel_data = OUT_WIDTH'(pre_sel >> eff_shift);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            decim_q   <= '0;
            shift_q   <= '0;
            warm_q    <= '0;
            comb_en_q <= 1'b0;
            cap_q     <= 1'b0;
            clr_q     <= 1'b0;
            ovr_q     <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            comb_en_q <= 1'b0;
            cap_q     <= 1'b0;
            clr_q     <= 1'b0;
            ovr_q     <= 1'b0;
            if (abort) begin
                // Disable wins over everything in flight, including a capture this cycle.
                state_q <= StIdle;
                clr_q   <= 1'b1;
                valid_q <= 1'b0;
            end else begin
                comb_en_q <= tick;
                cap_q     <= comb_en_q;
                if (valid_q && data_ready_i) begin
                    valid_q <= 1'b0;
                end
                unique case (state_q)
                    StIdle: begin
                        if (cfg_en_i) begin
                            state_q <= StClear;
                            clr_q   <= 1'b1;
                        end
                    end
                    StClear: begin
                        decim_q <= cfg_decim_i;
                        shift_q <= cfg_shift_i;
                        warm_q  <= '0;
                        state_q <= StWarmup;
                    end
                    StWarmup: begin
                        if (cap_q) begin
                            warm_q <= warm_q + WARM_W'(1);
                            if (warm_q == WARM_W'(NUM_STAGES - 1)) begin
                                state_q <= StRun;
                            end
                        end
                    end
                    StRun: begin
                        if (cap_q) begin
                            data_q  <= sel_data;
                            valid_q <= 1'b1;
                            ovr_q   <= valid_q && !data_ready_i;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl with a cycle-level reference model and an
// output scoreboard fed at capture time and drained on each handshake.
module tb_cic_decim_ctrl;

    localparam int unsigned W  = 64;
    localparam int unsigned OW = 16;
    localparam int unsigned NS = 5;
    localparam int unsigned DW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_en = 1'b0;
    logic [DW-1:0] cfg_decim = '0;
    logic [5:0]    cfg_shift = '0;
    logic          sample_valid = 1'b0;
    logic [W-1:0]  comb_data = '0;
    logic          data_ready = 1'b0;

    logic          integ_en_o, comb_en_o, cic_clr_o, data_valid_o, overrun_o, busy_o;
    logic [OW-1:0] data_o;

    cic_decim_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cfg_en_i       (cfg_en),
        .cfg_decim_i    (cfg_decim),
        .cfg_shift_i    (cfg_shift),
        .sample_valid_i (sample_valid),
        .integ_en_o     (integ_en_o),
        .comb_en_o      (comb_en_o),
        .cic_clr_o      (cic_clr_o),
        .comb_data_i    (comb_data),
        .data_o         (data_o),
        .data_valid_o   (data_valid_o),
        .data_ready_i   (data_ready),
        .overrun_o      (overrun_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model state (expected values for the current cycle).
    int          m_state = 0;
    int unsigned m_cnt = 0, m_decim = 0, m_shift = 0, m_warm = 0;
    logic        m_ce = 0, m_cap = 0, m_clr = 0, m_ovr = 0, m_valid = 0;
    logic [OW-1:0] exp_q[$];

    int unsigned   cyc = 0, ovr_cnt = 0, n_xfer = 0, m_runcap = 0;
    logic [OW-1:0] last_xfer = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [OW-1:0] sel(input logic [W-1:0] d, input int unsigned s);
        int unsigned  es;
        logic [W-1:0] v;
        es = (s > W - OW) ? W - OW : s;
        v  = d;
`ifdef CIC_DECIM_ROUND_EN
        if (es != 0) v = d + (64'd1 << (es - 1));
`endif
        return OW'(v >> es);
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_decim = 0; m_shift = 0; m_warm = 0;
        m_ce = 0; m_cap = 0; m_clr = 0; m_ovr = 0; m_valid = 0;
        exp_q.delete();
    endtask

    task automatic model_cycle();
        logic v0, abort, gated, n_ce, n_cap, n_clr, n_ovr;
        logic [OW-1:0] e;
        cyc++;
        chk("comb_en", 64'(comb_en_o), 64'(m_ce));
        chk("cic_clr", 64'(cic_clr_o), 64'(m_clr));
        chk("overrun", 64'(overrun_o), 64'(m_ovr));
        chk("data_valid", 64'(data_valid_o), 64'(m_valid));
        chk("busy", 64'(busy_o), 64'(m_state != 0));
        chk("integ_en", 64'(integ_en_o), 64'(sample_valid && (m_state >= 2)));
        if (overrun_o === 1'b1) ovr_cnt++;
        if (m_valid && data_ready) begin
            chk("sb_depth", 64'(exp_q.size()), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("data", 64'(data_o), 64'(e));
                n_xfer++;
                last_xfer = data_o;
            end
        end
        v0 = m_valid;
        abort = (m_state != 0) && !cfg_en;
        n_ce = 0; n_cap = 0; n_clr = 0; n_ovr = 0;
        if (abort) begin
            m_state = 0; n_clr = 1; m_valid = 0;
            exp_q.delete();
        end else begin
            n_cap = m_ce;
            gated = sample_valid && (m_state >= 2);
            if (gated) begin
                if (m_cnt == m_decim) begin m_cnt = 0; n_ce = 1; end
                else m_cnt++;
            end
            if (v0 && data_ready) m_valid = 0;
            case (m_state)
                0: if (cfg_en) begin m_state = 1; n_clr = 1; end
                1: begin
                    m_decim = cfg_decim; m_shift = cfg_shift;
                    m_warm = 0; m_cnt = 0; m_state = 2;
                end
                2: if (m_cap) begin
                    m_warm++;
                    if (m_warm == NS) m_state = 3;
                end
                default: if (m_cap) begin
                    if (v0 && !data_ready) begin n_ovr = 1; exp_q.delete(); end
                    exp_q.push_back(sel(comb_data, m_shift));
                    m_valid = 1;
                    m_runcap++;
                end
            endcase
        end
        m_ce = n_ce; m_cap = n_cap; m_clr = n_clr; m_ovr = n_ovr;
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input int unsigned d, input int unsigned s);
        cfg_en = 1'b0;
        step();
        step();
        cfg_decim = DW'(d);
        cfg_shift = 6'(s);
        cfg_en    = 1'b1;
        step();
        step();
    endtask

    logic [OW-1:0] hold;
    logic          found;

    initial begin
        // Reset values
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_valid", 64'(data_valid_o), 64'd0);
        chk("rst_overrun", 64'(overrun_o), 64'd0);
        chk("rst_comb_en", 64'(comb_en_o), 64'd0);
        chk("rst_clr", 64'(cic_clr_o), 64'd0);
        chk("rst_integ", 64'(integ_en_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        rst = 1'b0;
        model_reset();
        step();

        // decim=3, shift=0, one sample every 2 cycles: comb tick every 8 cycles
        data_ready = 1'b1;
        restart(3, 0);
        n_xfer = 0;
        for (int i = 0; i < 90; i++) begin
            sample_valid = (i % 2) == 1;
            comb_data = {$urandom(), $urandom()};
            step();
        end
        chk("xfer_A", 64'(n_xfer > 0), 64'd1);

        // decim=0, sample every cycle, incrementing comb data, always ready
        restart(0, 4);
        ovr_cnt = 0;
        n_xfer = 0;
        for (int i = 0; i < 30; i++) begin
            sample_valid = 1'b1;
            comb_data = W'(cyc) << 4;
            step();
        end
        chk("no_overrun_B", 64'(ovr_cnt), 64'd0);
        chk("xfer_B", 64'(n_xfer > 15), 64'd1);

        // Consumer stalled across two RUN captures: one overwrite, one overrun pulse
        data_ready = 1'b0;
        restart(3, 8);
        ovr_cnt = 0;
        m_runcap = 0;
        for (int i = 0; i < 120 && m_runcap < 2; i++) begin
            sample_valid = 1'b1;
            comb_data = {$urandom(), $urandom()};
            step();
        end
        chk("runcap_C", 64'(m_runcap), 64'd2);
        data_ready = 1'b1;
        repeat (3) step();
        chk("overrun_once", 64'(ovr_cnt), 64'd1);

        // Scaling: 0x1_8000 >> 16 truncates to 1, rounds to 2
        comb_data = 64'h1_8000;
        restart(1, 16);
        n_xfer = 0;
        for (int i = 0; i < 100 && n_xfer == 0; i++) begin
            sample_valid = 1'b1;
            step();
        end
`ifdef CIC_DECIM_ROUND_EN
        chk("round_16", 64'(last_xfer), 64'h2);
`else
        chk("trunc_16", 64'(last_xfer), 64'h1);
`endif

        // Shift above WIDTH-OUT_WIDTH clamps to the top OUT_WIDTH bits
        comb_data = 64'hABCD_0000_0000_0000;
        restart(1, 63);
        n_xfer = 0;
        for (int i = 0; i < 100 && n_xfer == 0; i++) begin
            sample_valid = 1'b1;
            step();
        end
        chk("clamp_shift", 64'(last_xfer), 64'hABCD);

        // Disable in the capture cycle (one cycle after comb_en_o)
        restart(3, 0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            sample_valid = 1'b1;
            comb_data = {$urandom(), $urandom()};
            step();
            if (m_state == 3 && comb_en_o === 1'b1) found = 1'b1;
        end
        chk("abort_found", 64'(found), 64'd1);
        step();
        hold = data_o;
        cfg_en = 1'b0;
        step();
        chk("abort_clr", 64'(cic_clr_o), 64'd1);
        chk("abort_valid", 64'(data_valid_o), 64'd0);
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_no_capture", 64'(data_o), 64'(hold));
        step();
        chk("abort_clr_once", 64'(cic_clr_o), 64'd0);

        // Asynchronous reset mid-RUN while holding valid data
        data_ready = 1'b0;
        restart(0, 0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            sample_valid = 1'b1;
            comb_data = {$urandom(), $urandom()};
            step();
            if (data_valid_o === 1'b1) found = 1'b1;
        end
        chk("valid_before_rst", 64'(found), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_data", 64'(data_o), 64'd0);
        chk("arst_valid", 64'(data_valid_o), 64'd0);
        chk("arst_overrun", 64'(overrun_o), 64'd0);
        chk("arst_comb_en", 64'(comb_en_o), 64'd0);
        chk("arst_clr", 64'(cic_clr_o), 64'd0);
        chk("arst_integ", 64'(integ_en_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cfg_en = 1'b0;
        sample_valid = 1'b0;
        model_reset();
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cic_decim_ctrl.md
# cic_decim_ctrl

Sequencing controller for the udma_i2s CIC decimation filter. Drives the shared enable and clear strobes of the integrator and comb chains and counts input samples to produce the decimated comb tick. It discards comb-pipeline fill outputs, then scales and truncates the last comb output. It presents each result on a valid/ready interface toward the uDMA RX path.

## Interface
- WIDTH, 64, width of the comb datapath
- OUT_WIDTH, 16, width of the output sample
- NUM_STAGES, 5, number of cascaded comb stages; this many first outputs are discarded
- DEC_WIDTH, 10, width of the decimation-ratio field
- clk_i  in  1  single clock for all logic
- rst_i  in  1  reset, asynchronous, active-high
- cfg_en_i  in  1  filter enable; level
- cfg_decim_i  in  DEC_WIDTH  decimation ratio minus 1
- cfg_shift_i  in  6  output right-shift amount
- sample_valid_i  in  1  one-cycle strobe marking a new PDM input sample
- integ_en_o  out  1  integrator-chain enable
- comb_en_o  out  1  comb-chain enable, one-cycle pulse per decimated tick
- cic_clr_o  out  1  synchronous clear to all integrator and comb stages
- comb_data_i  in  WIDTH  output of the last comb stage
- data_o  out  OUT_WIDTH  scaled output sample
- data_valid_o  out  1  data_o valid
- data_ready_i  in  1  consumer accepts data_o
- overrun_o  out  1  one-cycle pulse when an unconsumed sample is overwritten
- busy_o  out  1  high in every state except IDLE

## Operation
- States:
  - IDLE: on cfg_en_i=1, go to CLEAR.
  - CLEAR: one cycle with cic_clr_o=1. Latch cfg_decim_i and cfg_shift_i. Clear the decimation and warm-up counters. Go to WARMUP.
  - WARMUP: go to RUN after NUM_STAGES comb ticks.
  - RUN: steady-state operation.
- cfg_en_i=0 in any state other than IDLE:
  - next state is IDLE
  - cic_clr_o=1 for that one cycle
  - data_valid_o cleared
  - any pending capture is dropped
- integ_en_o is the same cycle as sample_valid_i, gated by state WARMUP or RUN.
- Decimation counter:
  - increments on each gated sample_valid_i
  - on a sample where count == the latched decim value, resets to 0 and schedules a comb tick
  - decim=0 means ratio 1, so every sample produces a tick
- Comb tick:
  - comb_en_o=1 in the cycle after the completing sample, so the integrators have already updated
  - the following cycle is the capture cycle
- Capture cycle in WARMUP: increments the warm-up counter only. data_o is not updated.
- Capture cycle in RUN:
  - data_o is loaded with bits [shift+OUT_WIDTH-1 : shift] of comb_data_i, using modular arithmetic
  - shift values above WIDTH-OUT_WIDTH clamp to WIDTH-OUT_WIDTH
  - data_valid_o is set
- Handshake:
  - transfer occurs when data_valid_o && data_ready_i
  - data_valid_o clears after a transfer unless a capture happens in the same cycle
- Capture while data_valid_o=1 and data_ready_i=0:
  - data_o is overwritten
  - overrun_o pulses for 1 cycle
- Capture with data_valid_o=1 and data_ready_i=1: transfer completes, new data is loaded, data_valid_o stays 1, no overrun.
- Latched config is not re-sampled until the next CLEAR.

## Timing
- Reset values:
  - state IDLE, all counters 0
  - integ_en_o=0, comb_en_o=0, cic_clr_o=0
  - data_o=0, data_valid_o=0, overrun_o=0, busy_o=0
- cfg_en_i rise at cycle T: cic_clr_o=1 in T+1, WARMUP from T+2.
- Completing sample at cycle S:
  - comb_en_o in S+1
  - capture in S+2
  - data_valid_o=1 from S+3
- sample_valid_i may be high every cycle. A new sample arriving during the comb_en_o or capture cycle is counted normally.
- Minimum spacing between comb ticks is one cycle (decim=0). comb_en_o and capture may overlap consecutive ticks, so the pipeline keeps up.
- cic_clr_o and comb_en_o are never high in the same cycle.

## Configuration
- Macro CIC_DECIM_ROUND_EN:
  - defined: before selection, compute comb_data_i + (1 << (shift-1)) in WIDTH bits with modular wrap. This is round-half-up. No rounding is applied when shift=0.
  - undefined: plain truncation, and no adder is instantiated.

## Structure
- Package cic_pkg holds:
  - the state enum: IDLE, CLEAR, WARMUP, RUN
  - the shift field width constant (6)
  - the default parameter constants
- One sub-module, cic_decim_counter. It holds the decimation counter and tick generation:
  - inputs: clear, enable, sample strobe, ratio
  - output: tick

## Test plan
- decim=3, shift=0, one sample every 2 cycles → comb_en_o every 8 cycles. The first 5 captures are dropped and the 6th sets data_valid_o.
- decim=0, sample_valid_i held high, data_ready_i=1, comb_data_i = incrementing count → comb_en_o every cycle, one output per cycle, overrun_o never asserted.
- data_ready_i=0 in RUN across two captures → second capture overwrites data_o and overrun_o pulses exactly once.
- comb_data_i=0x1_8000, shift=16:
  - without CIC_DECIM_ROUND_EN → data_o=0x0001
  - with CIC_DECIM_ROUND_EN → data_o=0x0002
- cfg_en_i dropped one cycle after comb_en_o → no capture occurs, cic_clr_o=1 for one cycle, data_valid_o=0, IDLE next.
- rst_i asserted mid-RUN with data_valid_o=1 → all outputs 0 immediately, without waiting for a clock edge.
